// File: rtl/div47_seq_if.sv
// Operand/result handshake bundle for the divide-by-47 controller.
// valid/ready: a transfer happens on a rising clk edge where both are high; valid never waits on ready.
interface div47_seq_if #(
    parameter int W = 36
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_dividend;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_quotient;
    logic [5:0]   out_remainder;

    modport master (
        output in_valid, in_dividend, out_ready,
        input  in_ready, out_valid, out_quotient, out_remainder
    );

    modport slave (
        input  in_valid, in_dividend, out_ready,
        output in_ready, out_valid, out_quotient, out_remainder
    );
endinterface

// File: rtl/div47_seq.sv
// Sequential unsigned divide-by-47: one radix-8 digit per cycle, MSB digit first.
// W must be a multiple of 3 in 3..48.
module div47_seq #(
    parameter int W = 36
) (
    input  logic        clk,
    input  logic        rst,
    div47_seq_if.slave  bus,
    output logic        busy,
    output logic [1:0]  dbg_state
);
    localparam int ND = W / 3;
    localparam int CW = (ND > 1) ? $clog2(ND) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  digit_q, digit_d;
    logic [W-1:0]  quot_q, quot_d;
    logic [5:0]    rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [8:0] step_w;
    logic [2:0] step_q;
    logic [5:0] step_r;

    // {r, d} is exactly 8*r + d; with r < 47 it stays below 384, so q fits in 3 bits.
    always_comb begin
        step_w = {rem_q, digit_q[W-1 -: 3]};
        step_q = 3'(step_w / 9'd47);
        step_r = 6'(step_w % 9'd47);
    end

    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    digit_d = bus.in_dividend;
                    quot_d  = '0;
                    rem_d   = '0;
                    cnt_d   = CW'(ND - 1);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                digit_d = digit_q << 3;
                quot_d  = (quot_q << 3) | W'(step_q);
                rem_d   = step_r;
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            digit_q <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            digit_q <= digit_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    // Accept only in IDLE, so the handshake-out cycle can never re-accept.
    assign bus.in_ready      = (state_q == ST_IDLE);
    assign bus.out_valid     = (state_q == ST_DONE);
    assign bus.out_quotient  = quot_q;
    assign bus.out_remainder = rem_q;
    assign busy              = (state_q != ST_IDLE);
    assign dbg_state         = state_q;
endmodule

// File: tb/tb_div47_seq.sv
// Self-checking bench for div47_seq: directed cases, backpressure, abort, streaming, W=6 instance.
// Reference results come from plain integer division by 47.
module tb_div47_seq;
    localparam int W        = 36;
    localparam int LAT      = W / 3;
    localparam int N_STREAM = 2000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy, busy6;
    logic [1:0] dbg_state, dbg_state6;
    logic       mon_en = 1'b0;
    int         n_checks = 0;
    int         n_pass   = 0;

    logic [W+5:0] exp_q[$];

    div47_seq_if #(.W(W)) bus ();
    div47_seq_if #(.W(6)) bus6 ();

    div47_seq #(.W(W)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy), .dbg_state(dbg_state)
    );
    div47_seq #(.W(6)) dut6 (
        .clk(clk), .rst(rst), .bus(bus6), .busy(busy6), .dbg_state(dbg_state6)
    );

    always #5 clk = ~clk;

    // Residue must stay below 47 on every cycle of both instances.
    always @(negedge clk) begin
        if (mon_en) begin
            n_checks++;
            if ((bus.out_remainder < 6'd47) !== 1'b1 || (bus6.out_remainder < 6'd47) !== 1'b1)
                $display("FAIL residue_range: rem=%0d rem6=%0d required < 47",
                         bus.out_remainder, bus6.out_remainder);
            else
                n_pass++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W+5:0] ref_div(input logic [W-1:0] a);
        longint unsigned x;
        x = longint'(a);
        return {W'(x / 47), 6'(x % 47)};
    endfunction

    function automatic logic [W-1:0] rand_div();
        logic [63:0] t;
        int          k;
        k = $urandom_range(0, 7);
        t = {$urandom(), $urandom()};
        case (k)
            0:       return '0;
            1:       return '1;
            2:       return W'(47 * $urandom_range(0, 100000));
            3:       return W'($urandom_range(0, 200));
            default: return t[W-1:0];
        endcase
    endfunction

    task automatic run_one(input logic [W-1:0] a, input string tag);
        logic [W+5:0] e;
        int           lat;
        logic [63:0]  junk;
        e = ref_div(a);
        bus.in_valid    = 1'b1;
        bus.in_dividend = a;
        step();
        bus.in_valid    = 1'b0;
        junk            = {$urandom(), $urandom()};
        bus.in_dividend = junk[W-1:0];
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            step();
            lat++;
        end
        n_checks++;
        if (lat !== LAT) $display("FAIL %s_latency: got %0d required %0d", tag, lat, LAT);
        else n_pass++;
        n_checks++;
        if ({bus.out_quotient, bus.out_remainder} !== e)
            $display("FAIL %s_result: got q=%0d r=%0d required q=%0d r=%0d", tag,
                     bus.out_quotient, bus.out_remainder, e[W+5:6], e[5:0]);
        else n_pass++;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        n_checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01)
            $display("FAIL %s_release: got valid/ready=%b required 01", tag, {bus.out_valid, bus.in_ready});
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus6.in_valid = 1'b1;
        repeat (3) step();
        n_checks++;
        if ({bus.in_ready, bus.out_valid, busy} !== 3'b100)
            $display("FAIL reset_flags: got ready/valid/busy=%b required 100", {bus.in_ready, bus.out_valid, busy});
        else n_pass++;
        n_checks++;
        if ({bus.out_quotient, bus.out_remainder} !== '0)
            $display("FAIL reset_result: got q=%0d r=%0d required 0 0", bus.out_quotient, bus.out_remainder);
        else n_pass++;
        n_checks++;
        if ({bus6.in_ready, bus6.out_valid, busy6} !== 3'b100)
            $display("FAIL reset_flags6: got %b required 100", {bus6.in_ready, bus6.out_valid, busy6});
        else n_pass++;
        bus.in_valid  = 1'b0;
        bus6.in_valid = 1'b0;
        rst = 1'b0;
        mon_en = 1'b1;
        step();
    endtask

    task automatic test_directed();
        run_one(W'(47), "d47");
        run_one('1, "dmax");
        run_one('0, "d0");
        run_one(W'(46), "d46");
        run_one(W'(1000), "d1000");
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a, b;
        logic [W+5:0] ea, eb;
        int           n;
        int           bad;
        a = rand_div();
        b = rand_div();
        ea = ref_div(a);
        eb = ref_div(b);
        bus.in_valid    = 1'b1;
        bus.in_dividend = a;
        bus.out_ready   = 1'b0;
        step();
        bus.in_dividend = b;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            step();
            n++;
        end
        n_checks++;
        if (n !== LAT) $display("FAIL bp_latency: got %0d required %0d", n, LAT);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if ({bus.out_quotient, bus.out_remainder} !== ea || {bus.in_ready, bus.out_valid} !== 2'b01) bad++;
            step();
        end
        n_checks++;
        if (bad !== 0) $display("FAIL bp_hold: got %0d unstable cycles required 0", bad);
        else n_pass++;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        n_checks++;
        if ({bus.in_ready, busy} !== 2'b10)
            $display("FAIL bp_release: got ready/busy=%b required 10", {bus.in_ready, busy});
        else n_pass++;
        n_checks++;
        if ({bus.out_quotient, bus.out_remainder} !== ea)
            $display("FAIL bp_idle_hold: got q=%0d r=%0d required q=%0d r=%0d",
                     bus.out_quotient, bus.out_remainder, ea[W+5:6], ea[5:0]);
        else n_pass++;
        step();
        bus.in_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL bp_next_accept: got busy=%b required 1", busy);
        else n_pass++;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            step();
            n++;
        end
        n_checks++;
        if ({bus.out_quotient, bus.out_remainder} !== eb || n !== LAT)
            $display("FAIL bp_second: got q=%0d r=%0d lat=%0d required q=%0d r=%0d lat=%0d",
                     bus.out_quotient, bus.out_remainder, n, eb[W+5:6], eb[5:0], LAT);
        else n_pass++;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_abort();
        int seen;
        bus.in_valid    = 1'b1;
        bus.in_dividend = W'(12345678);
        step();
        bus.in_valid = 1'b0;
        repeat (4) step();
        n_checks++;
        if (busy !== 1'b1) $display("FAIL abort_running: got busy=%b required 1", busy);
        else n_pass++;
        rst = 1'b1;
        bus.out_ready = 1'b1;
        step();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        n_checks++;
        if ({bus.in_ready, bus.out_valid, busy} !== 3'b100 || {bus.out_quotient, bus.out_remainder} !== '0)
            $display("FAIL abort_state: got ready/valid/busy=%b q=%0d r=%0d required 100 0 0",
                     {bus.in_ready, bus.out_valid, busy}, bus.out_quotient, bus.out_remainder);
        else n_pass++;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.out_valid) seen++;
            step();
        end
        n_checks++;
        if (seen !== 0) $display("FAIL abort_no_result: got %0d valid cycles required 0", seen);
        else n_pass++;
        run_one(W'(94), "after_abort");
    endtask

    task automatic test_back_to_back();
        int           acc[$];
        int           rx;
        logic [W+5:0] e;
        logic         took;
        int           n;
        exp_q.delete();
        rx = 0;
        bus.out_ready   = 1'b1;
        bus.in_valid    = 1'b1;
        bus.in_dividend = rand_div();
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (bus.out_valid) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({bus.out_quotient, bus.out_remainder} !== e)
                    $display("FAIL b2b_result: got q=%0d r=%0d required q=%0d r=%0d",
                             bus.out_quotient, bus.out_remainder, e[W+5:6], e[5:0]);
                else n_pass++;
            end
            took = bus.in_ready;
            if (took) begin
                acc.push_back(cyc);
                exp_q.push_back(ref_div(bus.in_dividend));
            end
            step();
            if (took) bus.in_dividend = rand_div();
        end
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            step();
            n++;
        end
        e = exp_q.pop_front();
        n_checks++;
        if ({bus.out_quotient, bus.out_remainder} !== e || !bus.out_valid)
            $display("FAIL b2b_last: got q=%0d r=%0d valid=%b required q=%0d r=%0d",
                     bus.out_quotient, bus.out_remainder, bus.out_valid, e[W+5:6], e[5:0]);
        else n_pass++;
        step();
        bus.out_ready = 1'b0;
        n_checks++;
        if (acc.size() < 3 || acc[1] - acc[0] !== LAT + 2 || acc[2] - acc[1] !== LAT + 2)
            $display("FAIL b2b_interval: got %0d accepts, gap %0d required gap %0d",
                     acc.size(), (acc.size() > 1) ? acc[1] - acc[0] : -1, LAT + 2);
        else n_pass++;
    endtask

    task automatic test_stream();
        int rx;
        int bad;
        exp_q.delete();
        rx  = 0;
        bad = 0;
        fork
            begin : driver
                logic [W-1:0] a;
                int           wt;
                for (int i = 0; i < N_STREAM; i++) begin
                    bus.in_valid = 1'b0;
                    repeat ($urandom_range(0, 3)) step();
                    a = rand_div();
                    bus.in_valid    = 1'b1;
                    bus.in_dividend = a;
                    wt = 0;
                    while (!bus.in_ready && wt < 300) begin
                        step();
                        wt++;
                    end
                    if (wt >= 300) begin
                        n_checks++;
                        $display("FAIL stream_accept_timeout: operand %0d not accepted", i);
                        break;
                    end
                    exp_q.push_back(ref_div(a));
                    step();
                    bus.in_valid = 1'b0;
                end
                bus.in_valid = 1'b0;
            end
            begin : monitor
                logic [W+5:0] e;
                int           cyc;
                cyc = 0;
                while (rx < N_STREAM && cyc < N_STREAM * 40) begin
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    if (bus.out_valid && bus.out_ready) begin
                        if (exp_q.size() == 0) begin
                            bad++;
                            $display("FAIL stream_extra: unexpected result q=%0d r=%0d",
                                     bus.out_quotient, bus.out_remainder);
                        end else begin
                            e = exp_q.pop_front();
                            n_checks++;
                            if ({bus.out_quotient, bus.out_remainder} !== e)
                                $display("FAIL stream_result: got q=%0d r=%0d required q=%0d r=%0d",
                                         bus.out_quotient, bus.out_remainder, e[W+5:6], e[5:0]);
                            else n_pass++;
                        end
                        rx++;
                    end
                    step();
                    cyc++;
                end
                bus.out_ready = 1'b0;
            end
        join
        n_checks++;
        if (rx !== N_STREAM || exp_q.size() !== 0 || bad !== 0)
            $display("FAIL stream_count: got %0d results, %0d pending, %0d extra required %0d 0 0",
                     rx, exp_q.size(), bad, N_STREAM);
        else n_pass++;
    endtask

    task automatic test_w6();
        logic [5:0]  vals[4];
        longint unsigned x;
        int          lat;
        vals[0] = 6'd63;
        vals[1] = 6'd47;
        vals[2] = 6'd46;
        vals[3] = 6'($urandom_range(0, 63));
        for (int i = 0; i < 4; i++) begin
            x = longint'(vals[i]);
            bus6.in_valid    = 1'b1;
            bus6.in_dividend = vals[i];
            step();
            bus6.in_valid = 1'b0;
            lat = 0;
            while (!bus6.out_valid && lat < 20) begin
                step();
                lat++;
            end
            n_checks++;
            if (lat !== 2 || bus6.out_quotient !== 6'(x / 47) || bus6.out_remainder !== 6'(x % 47))
                $display("FAIL w6_result: a=%0d got q=%0d r=%0d lat=%0d required q=%0d r=%0d lat=2",
                         vals[i], bus6.out_quotient, bus6.out_remainder, lat, x / 47, x % 47);
            else n_pass++;
            bus6.out_ready = 1'b1;
            step();
            bus6.out_ready = 1'b0;
        end
    endtask

    initial begin
        bus.in_valid     = 1'b0;
        bus.in_dividend  = '0;
        bus.out_ready    = 1'b0;
        bus6.in_valid    = 1'b0;
        bus6.in_dividend = '0;
        bus6.out_ready   = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_abort();
        test_back_to_back();
        test_stream();
        test_w6();
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
